// File: rtl/pipo_load_arbiter.sv
// Arbitrates NREQ write requesters onto a bank of NREG PIPO registers: grant, latch, then one-hot load strobe.
// Optional macro PIPO_ARB_RR_EN selects round-robin; otherwise lowest index wins.
module pipo_load_arbiter #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned NREQ  = 4,
   parameter int unsigned NREG  = 8,
   parameter int unsigned AW    = 3
) (
   input  logic                    clk,
   input  logic                    clr_n,
   input  logic [NREQ-1:0]         req_valid,
   input  logic [NREQ*AW-1:0]      req_addr,
   input  logic [NREQ*WIDTH-1:0]   req_data,
   input  logic                    hold,
   output logic [NREQ-1:0]         req_ready,
   output logic [NREG-1:0]         load_o,
   output logic [WIDTH-1:0]        data_o,
   output logic                    busy
);

   localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic {IDLE, LOAD} state_t;

   state_t            state, state_d;
   logic              pend_q, pend_d;
   logic [AW-1:0]     addr_q, addr_d;
   logic [WIDTH-1:0]  wdata_q, wdata_d;
   logic [NREQ-1:0]   ready_d;
   logic [NREG-1:0]   load_d;
   logic [WIDTH-1:0]  data_d;
   logic              busy_d;
   logic [IW-1:0]     win_c;
   logic              any_c;
   logic              grant_c;

`ifdef PIPO_ARB_RR_EN
   logic [IW-1:0]     rr_ptr, rr_ptr_d;

   // Search for the first pending request starting at rr_ptr, wrapping around.
   always_comb begin
      win_c = '0;
      any_c = 1'b0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         int unsigned idx;
         idx = (32'(rr_ptr) + k) % NREQ;
         if (!any_c && req_valid[idx]) begin
            any_c = 1'b1;
            win_c = IW'(idx);
         end
      end
   end

   always_comb begin
      rr_ptr_d = rr_ptr;
      if (grant_c) rr_ptr_d = IW'((32'(win_c) + 32'd1) % NREQ);
   end

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) rr_ptr <= '0;
      else        rr_ptr <= rr_ptr_d;
   end
`else
   // Fixed priority: lowest pending index wins.
   always_comb begin
      win_c = '0;
      any_c = 1'b0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         if (!any_c && req_valid[k]) begin
            any_c = 1'b1;
            win_c = IW'(k);
         end
      end
   end
`endif

   // Next-state and registered-output values; pend_q marks a granted write not yet strobed.
   always_comb begin
      state_d = state;
      pend_d  = pend_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      ready_d = '0;
      load_d  = '0;
      data_d  = data_o;
      grant_c = 1'b0;
      case (state)
         IDLE: begin
            if (!hold && any_c) grant_c = 1'b1;
         end
         LOAD: begin
            if (pend_q) begin
               if (!hold) begin
                  pend_d = 1'b0;
                  if (32'(addr_q) < NREG) begin
                     load_d = NREG'(1) << addr_q;
                     data_d = wdata_q;
                  end
               end
            end else if (!hold && any_c) begin
               grant_c = 1'b1;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      if (grant_c) begin
         state_d = LOAD;
         pend_d  = 1'b1;
         addr_d  = req_addr[win_c*AW +: AW];
         wdata_d = req_data[win_c*WIDTH +: WIDTH];
         ready_d = NREQ'(1) << win_c;
      end
      busy_d = (state_d == LOAD);
   end

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         state     <= IDLE;
         pend_q    <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         req_ready <= '0;
         load_o    <= '0;
         data_o    <= '0;
         busy      <= 1'b0;
      end else begin
         state     <= state_d;
         pend_q    <= pend_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         req_ready <= ready_d;
         load_o    <= load_d;
         data_o    <= data_d;
         busy      <= busy_d;
      end
   end

endmodule

// File: tb/tb_pipo_load_arbiter.sv
// Self-checking bench for pipo_load_arbiter: transaction-level model compared every cycle,
// directed literal checks, then randomized requesters, hold and resets.
module tb_pipo_load_arbiter;

   localparam int unsigned WIDTH = 16;
   localparam int unsigned NREQ  = 4;
   localparam int unsigned NREG  = 6;
   localparam int unsigned AW    = 3;

   logic                  clk;
   logic                  clr_n;
   logic [NREQ-1:0]       req_valid;
   logic [NREQ*AW-1:0]    req_addr;
   logic [NREQ*WIDTH-1:0] req_data;
   logic                  hold;
   logic [NREQ-1:0]       req_ready;
   logic [NREG-1:0]       load_o;
   logic [WIDTH-1:0]      data_o;
   logic                  busy;

   pipo_load_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .NREG(NREG), .AW(AW)) dut (
      .clk(clk), .clr_n(clr_n), .req_valid(req_valid), .req_addr(req_addr),
      .req_data(req_data), .hold(hold), .req_ready(req_ready), .load_o(load_o),
      .data_o(data_o), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model state: one outstanding granted write at most; expected outputs for the current cycle.
   logic [NREQ-1:0]  m_ready;
   logic [NREG-1:0]  m_load;
   logic [WIDTH-1:0] m_data;
   logic             m_busy;
   logic             m_pend;
   logic [AW-1:0]    m_addr;
   logic [WIDTH-1:0] m_pdata;
   int               m_rr;
   logic             m_strobe;
   int               m_w;

   int n_tests = 0;
   int n_fail  = 0;
   logic [NREQ-1:0] rdy_prev;

   function automatic int pick(input logic [NREQ-1:0] v, input int start);
      for (int k = 0; k < int'(NREQ); k++) begin
         int idx;
         idx = (start + k) % int'(NREQ);
         if (v[idx]) return idx;
      end
      return 0;
   endfunction

   always @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         m_ready = '0; m_load = '0; m_data = '0; m_busy = 1'b0;
         m_pend = 1'b0; m_addr = '0; m_pdata = '0; m_rr = 0;
      end else begin
         m_ready  = '0;
         m_load   = '0;
         m_strobe = 1'b0;
         if (m_pend) begin
            if (!hold) begin
               m_strobe = 1'b1;
               m_pend   = 1'b0;
               if (int'(m_addr) < int'(NREG)) begin
                  m_load = NREG'(1) << m_addr;
                  m_data = m_pdata;
               end
            end
         end else if (!hold && req_valid != '0) begin
`ifdef PIPO_ARB_RR_EN
            m_w = pick(req_valid, m_rr);
`else
            m_w = pick(req_valid, 0);
`endif
            m_ready = NREQ'(1) << m_w;
            m_pend  = 1'b1;
            m_addr  = req_addr[m_w*AW +: AW];
            m_pdata = req_data[m_w*WIDTH +: WIDTH];
            m_rr    = (m_w + 1) % int'(NREQ);
         end
         m_busy = m_pend || m_strobe;
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Advance to the next negedge and compare all outputs against the model.
   task automatic tick();
      @(negedge clk);
      chk("m_ready", 64'(req_ready), 64'(m_ready));
      chk("m_load",  64'(load_o),    64'(m_load));
      chk("m_busy",  64'(busy),      64'(m_busy));
      if (m_load != '0) chk("m_data", 64'(data_o), 64'(m_data));
   endtask

   task automatic set_req(input int i, input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
      req_valid[i] = 1'b1;
      req_addr[i*AW +: AW] = a;
      req_data[i*WIDTH +: WIDTH] = d;
   endtask

   task automatic do_reset();
      clr_n = 1'b0;
      tick();
      tick();
      clr_n = 1'b1;
   endtask

   logic [NREQ-1:0] exp_seq [5];

   initial begin
      clr_n = 1'b0; req_valid = '0; req_addr = '0; req_data = '0; hold = 1'b0;
      rdy_prev = '0;
      tick();
      tick();
      chk("rst_ready", 64'(req_ready), 64'h0);
      chk("rst_load",  64'(load_o),    64'h0);
      chk("rst_data",  64'(data_o),    64'h0);
      chk("rst_busy",  64'(busy),      64'h0);
      clr_n = 1'b1;

      // single request, addr 3
      set_req(0, 3'd3, 16'hA5A5);
      tick(); chk("t1_ready", 64'(req_ready), 64'h1);
      tick(); chk("t1_load", 64'(load_o), 64'h08); chk("t1_data", 64'(data_o), 64'hA5A5);
      req_valid = '0;
      tick(); chk("t1_busy", 64'(busy), 64'h0); chk("t1_load0", 64'(load_o), 64'h0);

      // hold for 3 cycles in LOAD
      set_req(1, 3'd5, 16'h1234);
      tick(); chk("t4_ready", 64'(req_ready), 64'h2);
      hold = 1'b1;
      tick(); req_valid = '0; chk("t4_h1", 64'(load_o), 64'h0);
      tick(); chk("t4_h2", 64'(load_o), 64'h0);
      tick(); chk("t4_h3", 64'(load_o), 64'h0);
      hold = 1'b0;
      tick(); chk("t4_load", 64'(load_o), 64'h20); chk("t4_data", 64'(data_o), 64'h1234);
      tick(); chk("t4_idle", 64'(busy), 64'h0);

      // all requesting: back-to-back slots
      do_reset();
`ifdef PIPO_ARB_RR_EN
      exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
`else
      exp_seq = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
`endif
      for (int i = 0; i < 4; i++) set_req(i, AW'(i), WIDTH'(16'h1000 + i));
      for (int s = 0; s < 5; s++) begin
         tick(); chk("t23_grant", 64'(req_ready), 64'(exp_seq[s]));
         tick(); chk("t23_busy", 64'(busy), 64'h1);
      end
      req_valid[0] = 1'b0;
      tick(); chk("t3_grant1", 64'(req_ready), 64'h2);
      tick(); chk("t3_load1", 64'(load_o), 64'h02);
      req_valid = '0;
      tick();
      tick();

      // reset during LOAD
      req_valid = '1;
      tick();
      #2 clr_n = 1'b0;
      #1;
      chk("t5_ready", 64'(req_ready), 64'h0);
      chk("t5_load",  64'(load_o),    64'h0);
      chk("t5_data",  64'(data_o),    64'h0);
      chk("t5_busy",  64'(busy),      64'h0);
      tick(); chk("t5_nostrobe", 64'(load_o), 64'h0);
      clr_n = 1'b1;
      tick(); chk("t5_first", 64'(req_ready), 64'h1);
      tick(); chk("t5_load0", 64'(load_o), 64'h01);
      req_valid = '0;
      tick();

      // out-of-range address dropped, next request served
      set_req(2, 3'd7, 16'hBEEF);
      tick(); chk("t6_ready", 64'(req_ready), 64'h4);
      tick(); chk("t6_drop", 64'(load_o), 64'h0); chk("t6_busy", 64'(busy), 64'h1);
      req_valid = '0;
      set_req(3, 3'd2, 16'h5A5A);
      tick(); chk("t6_ready3", 64'(req_ready), 64'h8);
      tick(); chk("t6_load", 64'(load_o), 64'h04); chk("t6_data", 64'(data_o), 64'h5A5A);
      req_valid = '0;
      tick();
      tick();

      // randomized requesters, hold and occasional reset
      for (int c = 0; c < 3000; c++) begin
         tick();
         for (int i = 0; i < int'(NREQ); i++) begin
            if (rdy_prev[i]) begin
               req_valid[i] = ($urandom_range(0, 1) == 1);
               req_addr[i*AW +: AW] = AW'($urandom_range(0, 7));
               req_data[i*WIDTH +: WIDTH] = WIDTH'($urandom);
            end else if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
               set_req(i, AW'($urandom_range(0, 7)), WIDTH'($urandom));
            end
         end
         rdy_prev = req_ready;
         hold  = ($urandom_range(0, 3) == 0);
         clr_n = ($urandom_range(0, 299) != 0);
      end
      clr_n = 1'b1; hold = 1'b0; req_valid = '0;
      tick();
      tick();
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
